req_data_initiator: RTL and testbench
=====================================

Name: req_data_initiator

Overview:
- Initiator-side driver for the a/b/req_data request interface whose monitor checks that `$rose(a)` coincides with `$rose(req_data)` and that a&&b is sampled at that edge.
- Issues a programmable burst of requests. Each request carries one data bit on b. After each request the block waits for the responder's flag acknowledge, then releases the interface before issuing the next request.
- Sits in the bench/SoC fabric in front of the responder block and provides the stimulus end of the same protocol.

Parameters:
- DATA_W, 8: width of b_pattern; request i drives b = b_pattern[i mod DATA_W].
- CNT_W, 8: width of num_req and req_count.
- ACK_TIMEOUT, 16: maximum cycles spent in WAIT_ACK before aborting (must be ≥1).
- GAP_CYCLES, 2: idle cycles between a release and the next request (must be ≥1).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle burst launch; sampled only in IDLE.
- num_req, input, CNT_W: number of requests in the burst; latched on accepted start.
- b_pattern, input, DATA_W: per-request data bits; latched on accepted start.
- flag, input, 1: responder acknowledge; sampled only in WAIT_ACK.
- a, output, 1: request qualifier; registered.
- b, output, 1: request data bit; registered.
- req_data, output, 1: request strobe; registered; rises in the same cycle as a.
- busy, output, 1: high from the cycle after start is accepted until DONE exits.
- done, output, 1: one-cycle pulse at burst end (normal or aborted).
- timeout_err, output, 1: sticky error; cleared on the next accepted start or by reset.
- req_count, output, CNT_W: number of requests acknowledged in the current/last burst.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 immediately; FSM to IDLE; latched num_req/b_pattern, counters and timer cleared. Reset mid-transaction drops a/req_data/b in the same instant; there is no completion.
- FSM states: IDLE, ISSUE, WAIT_ACK, RELEASE, GAP, DONE.
- IDLE:
  - a=b=req_data=0; busy=0.
  - start=1 with num_req≠0: latch inputs; clear req_count, index and timeout_err; go to ISSUE.
  - start=1 with num_req=0: clear timeout_err; go to DONE (no request issued).
- ISSUE (1 cycle):
  - a=1, req_data=1, b=pattern[index], all rising together.
  - Latency: start sampled at edge k → a/req_data high after edge k+1.
  - Go to WAIT_ACK; clear timer.
- WAIT_ACK:
  - Hold a, req_data and b stable.
  - flag=1 sampled → go to RELEASE.
  - Otherwise increment the timer. If the timer reaches ACK_TIMEOUT-1 without flag: set timeout_err, drive a/req_data/b low, go to DONE. Abort path; req_count is not incremented.
  - Exactly ACK_TIMEOUT wait cycles are allowed. flag arriving on the last allowed cycle counts as an acknowledge; flag takes priority over timeout when both occur in the same cycle.
- RELEASE (1 cycle):
  - a=b=req_data=0; req_count+1; index+1, wrapping modulo DATA_W.
  - If the new req_count equals latched num_req → DONE; else → GAP.
- GAP:
  - Outputs low for GAP_CYCLES cycles, then → ISSUE.
  - Guarantees a fresh `$rose` on every request.
  - flag is ignored here and in ISSUE.
- DONE (1 cycle): done=1, then busy=0 and → IDLE.
- start while busy is ignored; the latched inputs do not change.
- req_count saturates: it cannot exceed num_req.
- Arithmetic is unsigned; num_req maximum is 2^CNT_W-1.

Test Plan:
- Normal burst:
  - Stimulus: reset, then start with num_req=3, b_pattern=8'b0000_0101; responder raises flag 2 cycles after each req_data rise.
  - Required: three a/req_data rising pulses with b=1,0,1; each pulse high for 3 cycles; 3 low cycles between pulses (RELEASE + GAP_CYCLES=2); req_count=3; one done pulse; timeout_err=0.
- Timeout:
  - Stimulus: num_req=2, flag held 0.
  - Required: a/req_data high for 1 ISSUE cycle + 16 WAIT_ACK cycles, then low; timeout_err=1; done pulse; req_count=0; no second request issued.
- Zero-length burst:
  - Stimulus: start with num_req=0.
  - Required: done pulse 1 cycle after start; a/req_data never rise; busy stays 0.
- Async reset mid-transaction:
  - Stimulus: rst_n=0 asynchronously during WAIT_ACK.
  - Required: a, b, req_data, busy, done, req_count = 0 before the next clk edge.
  - Then rst_n=1 and start with num_req=1 → normal single request.
- Pattern wrap and busy start:
  - Stimulus: DATA_W=8, num_req=10, b_pattern=8'h81, immediate flag; pulse start again during the burst.
  - Required: b sequence 1,0,0,0,0,0,0,1,1,0; the second start has no effect; req_count=10.
- Late acknowledge on the boundary:
  - Stimulus: flag asserted on exactly the 16th WAIT_ACK cycle.
  - Required: treated as an acknowledge; timeout_err=0; burst continues.

Source files
------------

// File: rtl/req_data_initiator_if.sv
// Request-side bus of the a/b/req_data initiator: burst control in, request/status out.
interface req_data_initiator_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) ();

   logic              start;
   logic [CNT_W-1:0]  num_req;
   logic [DATA_W-1:0] b_pattern;
   logic              flag;
   logic              a;
   logic              b;
   logic              req_data;
   logic              busy;
   logic              done;
   logic              timeout_err;
   logic [CNT_W-1:0]  req_count;

   // Initiator side: drives the request lines and burst status.
   modport master (
      input  start, num_req, b_pattern, flag,
      output a, b, req_data, busy, done, timeout_err, req_count
   );

   // Controller/responder side: launches bursts, acknowledges requests.
   modport slave (
      output start, num_req, b_pattern, flag,
      input  a, b, req_data, busy, done, timeout_err, req_count
   );

endinterface

// File: rtl/req_data_initiator.sv
// Burst request initiator: issues num_req a/req_data requests carrying one
// b_pattern bit each, waits for a flag acknowledge with a bounded timeout,
// and leaves a gap between requests so every request is a fresh rising edge.
// All interface outputs are registered copies of the previous cycle's state.
module req_data_initiator #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   req_data_initiator_if.master bus
);

   localparam int unsigned IDX_W = (DATA_W > 1)      ? $clog2(DATA_W)      : 1;
   localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_GAP     = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    num_q,   num_d;
   logic [DATA_W-1:0]   pat_q,   pat_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [TMR_W-1:0]    tmr_q,   tmr_d;
   logic [GAP_W-1:0]    gap_q,   gap_d;
   logic                terr_q,  terr_d;

   logic                a_q;
   logic                b_q;
   logic                busy_q;
   logic                done_q;

   // State, latched burst parameters and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         pat_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         gap_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         gap_q   <= gap_d;
         terr_q  <= terr_d;
      end
   end

   // Next-state logic for the burst sequencer.
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      gap_d   = gap_q;
      terr_d  = terr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               terr_d = 1'b0;
               if (bus.num_req != '0) begin
                  num_d   = bus.num_req;
                  pat_d   = bus.b_pattern;
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_ISSUE: begin
            tmr_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // Acknowledge wins over timeout on the last allowed cycle.
            if (bus.flag) begin
               state_d = ST_RELEASE;
            end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         ST_RELEASE: begin
            if (cnt_q != num_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            idx_d = (idx_q == IDX_W'(DATA_W - 1)) ? '0 : idx_q + IDX_W'(1);
            gap_d = '0;
            state_d = (cnt_d == num_q) ? ST_DONE : ST_GAP;
         end

         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = ST_ISSUE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered interface outputs, one cycle behind the sequencer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= 1'b0;
         b_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= (state_q == ST_ISSUE) || (state_q == ST_WAIT);
         b_q    <= ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && pat_q[idx_q];
         busy_q <= (state_q != ST_IDLE) && (state_q != ST_DONE);
         done_q <= (state_q == ST_DONE);
      end
   end

   assign bus.a           = a_q;
   assign bus.req_data    = a_q;
   assign bus.b           = b_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = terr_q;
   assign bus.req_count   = cnt_q;

endmodule

// File: tb/tb_req_data_initiator.sv
// Bench for req_data_initiator: each burst is turned into an expected
// per-cycle timeline (request windows, acknowledges, done/busy, status)
// from the protocol timing rules, and the DUT is compared cycle by cycle.
module tb_req_data_initiator;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned ACK_TIMEOUT = 16;
   localparam int unsigned GAP_CYCLES  = 2;
   localparam int          MAXC        = 2048;
   localparam int          IDLE_TAIL   = 3;

   logic clk;
   logic rst_n;

   req_data_initiator_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   req_data_initiator #(
      .DATA_W(DATA_W), .CNT_W(CNT_W),
      .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_err;
   int cur_c;

   // Expected timeline, indexed by cycle after the start-sampling edge.
   bit e_a    [MAXC];
   bit e_b    [MAXC];
   bit e_busy [MAXC];
   bit e_done [MAXC];
   bit e_terr [MAXC];
   bit e_flag [MAXC];
   int e_cnt  [MAXC];

   // Per-request acknowledge wait (1..ACK_TIMEOUT), 0 means never acknowledged.
   int waits_q[$];
   int prev_cnt;
   bit prev_terr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cur_c, obs, exp);
      end
   endtask

   task automatic check_outputs(input int c);
      cur_c = c;
      check("a",        32'(bus.a),           32'(e_a[c]));
      check("req_data", 32'(bus.req_data),    32'(e_a[c]));
      check("b",        32'(bus.b),           32'(e_b[c]));
      check("busy",     32'(bus.busy),        32'(e_busy[c]));
      check("done",     32'(bus.done),        32'(e_done[c]));
      check("terr",     32'(bus.timeout_err), 32'(e_terr[c]));
      check("count",    32'(bus.req_count),   32'(e_cnt[c]));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"},     32'(bus.a),           32'd0);
      check({tag, "_rd"},    32'(bus.req_data),    32'd0);
      check({tag, "_b"},     32'(bus.b),           32'd0);
      check({tag, "_busy"},  32'(bus.busy),        32'd0);
      check({tag, "_done"},  32'(bus.done),        32'd0);
      check({tag, "_terr"},  32'(bus.timeout_err), 32'd0);
      check({tag, "_count"}, 32'(bus.req_count),   32'd0);
   endtask

   // Launch a burst at the current negedge, run it plus an idle tail.
   // abort_c >= 0 pulls rst_n low in the middle of that cycle instead.
   task automatic run_burst(input int num, input logic [7:0] pat, input int abort_c);
      int d_end, r, w, last;
      d_end = 1;
      r = 1;
      if (num != 0) begin
         for (int j = 0; j < num; j++) begin
            w = (j < waits_q.size()) ? waits_q[j] : 1;
            if (w == 0) begin
               d_end = r + int'(ACK_TIMEOUT) + 1;
               break;
            end else if (j == num - 1) begin
               d_end = r + w + 2;
            end else begin
               r = r + w + 2 + int'(GAP_CYCLES);
            end
         end
      end
      last = d_end + IDLE_TAIL - 1;

      for (int c = 0; c <= last; c++) begin
         e_a[c]    = 1'b0;
         e_b[c]    = 1'b0;
         e_busy[c] = (num != 0) && (c >= 1) && (c <= d_end - 1);
         e_done[c] = (c == d_end);
         e_terr[c] = 1'b0;
         e_cnt[c]  = (num == 0) ? prev_cnt : 0;
         e_flag[c] = 1'($urandom);
      end

      r = 1;
      for (int j = 0; j < num; j++) begin
         int hi, wl;
         w  = (j < waits_q.size()) ? waits_q[j] : 1;
         hi = (w == 0) ? int'(ACK_TIMEOUT) + 1 : w + 1;
         wl = (w == 0) ? int'(ACK_TIMEOUT) : w;
         for (int c = r; c < r + hi; c++) begin
            e_a[c] = 1'b1;
            e_b[c] = pat[j % int'(DATA_W)];
         end
         for (int k = 0; k < wl; k++) e_flag[r + k] = (w != 0) && (k == wl - 1);
         if (w == 0) begin
            for (int c = d_end - 1; c <= last; c++) e_terr[c] = 1'b1;
            break;
         end
         for (int c = r + w + 1; c <= last; c++) e_cnt[c] = j + 1;
         r = r + w + 2 + int'(GAP_CYCLES);
      end

      bus.start     = 1'b1;
      bus.num_req   = CNT_W'(num);
      bus.b_pattern = pat;
      bus.flag      = 1'($urandom);
      @(posedge clk);

      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         if ((c <= d_end - 2) && ((c == 2) || ($urandom_range(3, 0) == 0))) begin
            bus.start     = 1'b1;
            bus.num_req   = CNT_W'($urandom_range(12, 0));
            bus.b_pattern = DATA_W'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         bus.flag = e_flag[c];
         check_outputs(c);
         if (c == abort_c) begin
            bus.start = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_all_zero("async_rst");
            @(negedge clk);
            check_all_zero("in_rst");
            rst_n     = 1'b1;
            prev_cnt  = 0;
            prev_terr = 1'b0;
            return;
         end
      end
      prev_cnt  = e_cnt[last];
      prev_terr = e_terr[last];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      cur_c = -1;
      prev_cnt  = 0;
      prev_terr = 1'b0;
      rst_n = 1'b0;
      bus.start     = 1'b0;
      bus.num_req   = '0;
      bus.b_pattern = '0;
      bus.flag      = 1'b0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Normal burst: acknowledge on the second wait cycle each time.
      waits_q = '{2, 2, 2};
      run_burst(3, 8'b0000_0101, -1);

      // Timeout on the first request; second never issued.
      waits_q = '{0, 1};
      run_burst(2, 8'hFF, -1);

      // Zero-length burst.
      waits_q = '{};
      run_burst(0, 8'hA5, -1);

      // Async reset while waiting for acknowledge, then a plain single request.
      waits_q = '{int'(ACK_TIMEOUT)};
      run_burst(1, 8'h01, 5);
      waits_q = '{3};
      run_burst(1, 8'h01, -1);

      // Pattern wrap with immediate acknowledges and a start pulsed mid-burst.
      waits_q = '{};
      for (int j = 0; j < 10; j++) waits_q.push_back(1);
      run_burst(10, 8'h81, -1);

      // Acknowledge on the last allowed wait cycle.
      waits_q = '{int'(ACK_TIMEOUT), 1};
      run_burst(2, 8'h02, -1);

      // Randomized bursts.
      for (int t = 0; t < 20; t++) begin
         int num;
         num = $urandom_range(12, 0);
         waits_q = '{};
         for (int j = 0; j < num; j++) begin
            if ($urandom_range(7, 0) == 0) waits_q.push_back(0);
            else waits_q.push_back(int'($urandom_range(ACK_TIMEOUT, 1)));
         end
         run_burst(num, 8'($urandom), -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
